fb_burst_target: RTL

- Frame-buffer memory target on the shared command bus, directly upstream of the video controller.
- Accepts burst read requests from the controller's pixel-fetch engine and returns packed RGB words (R=[23:16], G=[15:8], B=[7:0]) as data beats.
- Accepts burst writes so that software or the bench can preload the frame.
- Contains word-addressed storage, burst sequencing and arbiter bid/ack handshake.

---
 rtl/fb_burst_target.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/fb_burst_target.sv
// Frame-buffer burst target: word storage answering burst reads/writes on the shared command bus.
// Latency: read bid appears RD_LATENCY+1 cycles after acceptance; one beat per cycle after grant.
// Backpressure: bids hold until ackin; write data stalls on any cmdin other than write-data; busy blocks new requests.
module fb_burst_target #(
    parameter logic [31:0] ADDR_BASE   = 32'h0001_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          RD_LATENCY  = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        selin,
    input  logic [2:0]  cmdin,
    input  logic [1:0]  lenin,
    input  logic [31:0] addrdatain,
    input  logic [3:0]  reqidin,
    input  logic        ackin,
    output logic [1:0]  reqout,
    output logic [2:0]  cmdout,
    output logic [1:0]  lenout,
    output logic [31:0] addrdataout,
    output logic [3:0]  reqtar,
    output logic        busy,
    output logic        err
);

    localparam int          AW         = $clog2(DEPTH_WORDS);
    // One past the last valid byte address; 33 bits so the end-of-burst compare cannot overflow.
    localparam logic [32:0] ADDR_LIMIT = {1'b0, ADDR_BASE} + (33'(DEPTH_WORDS) << 2);
    localparam logic [7:0]  WAIT_LAST  = 8'(RD_LATENCY);
    localparam logic [31:0] BAD_DATA   = 32'hDEAD_BEEF;

    localparam logic [2:0] CMD_RD_REQ = 3'b010;
    localparam logic [2:0] CMD_WR_REQ = 3'b100;
    localparam logic [2:0] CMD_WR_DAT = 3'b001;
    localparam logic [2:0] CMD_RD_DAT = 3'b011;
    localparam logic [2:0] CMD_WR_RSP = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_BID,
        RD_DATA,
        WR_DATA,
        WR_BID,
        WR_RESP
    } state_t;

    state_t      state;
    logic [31:0] addr_q;
    logic [1:0]  len_q;
    logic [3:0]  id_q;
    logic        bad_q;
    logic [3:0]  beat_q;
    logic [7:0]  wait_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [3:0]    req_beats;
    logic [32:0]   req_end;
    logic          req_bad;
    logic [3:0]    burst_beats;
    logic [31:0]   beat_addr;
    logic [AW-1:0] beat_idx;
    logic [31:0]   rd_word;
    logic          wr_en;
    logic          last_wr;

    // Request validation, current beat address and storage index for the active burst
    always_comb begin
        req_beats   = 4'd1 << lenin;
        req_end     = {1'b0, addrdatain} + {27'd0, req_beats, 2'b00};
        req_bad     = (addrdatain[1:0] != 2'b00) || (addrdatain < ADDR_BASE) || (req_end > ADDR_LIMIT);
        burst_beats = 4'd1 << len_q;
        beat_addr   = addr_q + {26'd0, beat_q, 2'b00};
        beat_idx    = AW'((beat_addr - ADDR_BASE) >> 2);
        rd_word     = bad_q ? BAD_DATA : mem[beat_idx];
        wr_en       = (state == WR_DATA) && (cmdin == CMD_WR_DAT) && !bad_q;
        last_wr     = (beat_q == burst_beats - 4'd1);
    end

    // Storage write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[beat_idx] <= addrdatain;
        end
    end

    // Burst sequencer with registered bus outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            id_q        <= '0;
            bad_q       <= 1'b0;
            beat_q      <= '0;
            wait_q      <= '0;
            reqout      <= 2'b00;
            cmdout      <= 3'b000;
            lenout      <= 2'b00;
            addrdataout <= '0;
            reqtar      <= '0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (selin && (cmdin == CMD_RD_REQ || cmdin == CMD_WR_REQ)) begin
                        addr_q <= addrdatain;
                        len_q  <= lenin;
                        id_q   <= reqidin;
                        bad_q  <= req_bad;
                        err    <= req_bad;
                        beat_q <= '0;
                        wait_q <= '0;
                        busy   <= 1'b1;
                        state  <= (cmdin == CMD_RD_REQ) ? RD_WAIT : WR_DATA;
                    end
                end
                RD_WAIT: begin
                    if (wait_q == WAIT_LAST) begin
                        reqout <= 2'b11;
                        reqtar <= id_q;
                        state  <= RD_BID;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                RD_BID: begin
                    if (ackin) begin
                        reqout      <= 2'b00;
                        cmdout      <= CMD_RD_DAT;
                        lenout      <= len_q;
                        addrdataout <= rd_word;
                        beat_q      <= beat_q + 4'd1;
                        state       <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    // beat_q has already advanced past the beat on the bus
                    if (beat_q == burst_beats) begin
                        cmdout      <= 3'b000;
                        lenout      <= 2'b00;
                        addrdataout <= '0;
                        reqtar      <= '0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        addrdataout <= rd_word;
                        beat_q      <= beat_q + 4'd1;
                    end
                end
                WR_DATA: begin
                    if (cmdin == CMD_WR_DAT) begin
                        beat_q <= beat_q + 4'd1;
                        if (last_wr) begin
                            reqout <= 2'b11;
                            reqtar <= id_q;
                            state  <= WR_BID;
                        end
                    end
                end
                WR_BID: begin
                    if (ackin) begin
                        reqout <= 2'b00;
                        cmdout <= CMD_WR_RSP;
                        lenout <= len_q;
                        state  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    cmdout <= 3'b000;
                    lenout <= 2'b00;
                    reqtar <= '0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
